// File: rtl/imem_loader_pkg.sv
// Shared types and framing constants for the instruction-memory loader.
// Used by the top-level FSM and the word assembler.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        PAYLOAD,
        CHECK,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects payload bytes LSB first and emits one registered 32-bit word per four bytes.
// The output word register is separate from the byte lanes so assembly can continue during a write.
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_byte,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0]                  byte_cnt_reg;
    logic [8*(BYTES_PER_WORD-1)-1:0]   lanes;
    logic [31:0]                       word_reg;
    logic                              word_valid_reg;

    assign last_byte = (byte_cnt_reg == CNT_W'(BYTES_PER_WORD - 1));

    // The final byte of a word goes straight into word_reg, so only the lower lanes need storage.
    genvar gi;
    generate
        for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
            logic [7:0] lane_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lane_reg <= '0;
                end else if (clear) begin
                    lane_reg <= '0;
                end else if (byte_valid && (byte_cnt_reg == CNT_W'(gi))) begin
                    lane_reg <= byte_data;
                end
            end

            assign lanes[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_reg   <= '0;
            word_reg       <= '0;
            word_valid_reg <= 1'b0;
        end else begin
            word_valid_reg <= 1'b0;
            if (clear) begin
                byte_cnt_reg <= '0;
            end else if (byte_valid) begin
                byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
                if (last_byte) begin
                    word_reg       <= {byte_data, lanes};
                    word_valid_reg <= 1'b1;
                end
            end
        end
    end

    assign word_valid = word_valid_reg;
    assign word       = word_reg;

endmodule

// File: rtl/imem_loader.sv
// Loads a framed, XOR-checksummed program image from a byte stream into instruction RAM
// and keeps the CPU held until a complete, verified image is in place.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wd,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int N_W = HDR_BYTES * 8;

    state_t             state_reg;
    state_t             state_next;

    logic               accept;
    logic               start_load;
    logic [N_W-1:0]     hdr_n;
    logic [N_W-1:0]     word_idx_inc;

    logic [7:0]         lo_reg;
    logic [N_W-1:0]     n_reg;
    logic [7:0]         xor_reg;
    logic [ADDR_W:0]    word_idx_reg;
    logic [ADDR_W:0]    words_loaded_reg;
    logic [31:0]        imem_addr_reg;

    logic               asm_last_byte;
    logic               asm_word_valid;
    logic [31:0]        asm_word;

    assign rx_ready     = (state_reg == HDR_LO) || (state_reg == HDR_HI) ||
                          (state_reg == PAYLOAD) || (state_reg == CHECK);
    assign accept       = rx_valid && rx_ready;
    assign start_load   = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERR));
    assign hdr_n        = {rx_data, lo_reg};
    assign word_idx_inc = N_W'(word_idx_reg) + N_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) state_next = HDR_LO;
            end
            HDR_LO: begin
                if (accept) state_next = HDR_HI;
            end
            HDR_HI: begin
                if (accept) begin
                    if (hdr_n > N_W'(DEPTH))  state_next = ERR;
                    else if (hdr_n == '0)     state_next = CHECK;
                    else                      state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (accept && asm_last_byte && (word_idx_inc == n_reg)) state_next = CHECK;
            end
            CHECK: begin
                if (accept) state_next = (rx_data == xor_reg) ? DONE : ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    // word_idx counts words handed to the assembler; words_loaded counts completed writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_reg           <= '0;
            n_reg            <= '0;
            xor_reg          <= '0;
            word_idx_reg     <= '0;
            words_loaded_reg <= '0;
            imem_addr_reg    <= '0;
        end else if (start_load) begin
            xor_reg          <= '0;
            word_idx_reg     <= '0;
            words_loaded_reg <= '0;
        end else begin
            if (asm_word_valid) begin
                words_loaded_reg <= words_loaded_reg + 1'b1;
            end
            if (accept) begin
                case (state_reg)
                    HDR_LO: lo_reg <= rx_data;
                    HDR_HI: n_reg  <= hdr_n;
                    PAYLOAD: begin
                        xor_reg <= xor_reg ^ rx_data;
                        if (asm_last_byte) begin
                            imem_addr_reg <= {{(30-ADDR_W){1'b0}}, word_idx_reg[ADDR_W-1:0], 2'b00};
                            word_idx_reg  <= word_idx_reg + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    word_assembler u_word_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (start_load),
        .byte_valid (accept && (state_reg == PAYLOAD)),
        .byte_data  (rx_data),
        .last_byte  (asm_last_byte),
        .word_valid (asm_word_valid),
        .word       (asm_word)
    );

    assign imem_we      = asm_word_valid;
    assign imem_wd      = asm_word;
    assign imem_addr    = imem_addr_reg;
    assign words_loaded = words_loaded_reg;
    assign busy         = rx_ready;
    assign done         = (state_reg == DONE);
    assign error        = (state_reg == ERR);
    assign cpu_hold     = (state_reg != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of complete frames plus hand-written
// sequences for oversize header, stream gaps with ignored start, and mid-load reset.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wd;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] words_loaded;

    imem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wd      (imem_wd),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [127:0] bytes;     // frame bytes, first byte in the top octet
        int           len;
        int           exp_nwr;
        logic [95:0]  exp_wd;    // expected word j at [32*j +: 32]
        logic         exp_done;
        logic         exp_error;
    } vec_t;

    vec_t vecs[5];

    int checks   = 0;
    int failures = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          overlap;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wd);
            if (done || error) overlap++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] frame_byte(input int v, input int i);
        logic [127:0] b;
        b = vecs[v].bytes;
        return b[8*(15-i) +: 8];
    endfunction

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited   = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (rx_ready !== 1'b1) begin
            check("rx_ready_timeout", {31'b0, rx_ready}, 32'h1);
        end else begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic check_result(input int v, input string tag);
        check({tag, "_done"},     {31'b0, done},     {31'b0, vecs[v].exp_done});
        check({tag, "_error"},    {31'b0, error},    {31'b0, vecs[v].exp_error});
        check({tag, "_cpu_hold"}, {31'b0, cpu_hold}, {31'b0, ~vecs[v].exp_done});
        check({tag, "_busy"},     {31'b0, busy},     32'h0);
        check({tag, "_rx_ready"}, {31'b0, rx_ready}, 32'h0);
        check({tag, "_words"},    {21'b0, words_loaded}, vecs[v].exp_nwr);
        check({tag, "_nwrites"},  wr_addr_q.size(), vecs[v].exp_nwr);
        check({tag, "_overlap"},  overlap, 32'h0);
        for (int j = 0; j < vecs[v].exp_nwr && j < wr_addr_q.size(); j++) begin
            check($sformatf("%s_addr%0d", tag, j), wr_addr_q[j], 32'(j * 4));
            check($sformatf("%s_data%0d", tag, j), wr_data_q[j], vecs[v].exp_wd[32*j +: 32]);
        end
    endtask

    // gaps: idle cycle before every byte, and a start pulse overlapping a payload byte
    task automatic run_frame(input int v, input bit gaps, input string tag);
        wr_addr_q.delete();
        wr_data_q.delete();
        overlap = 0;
        pulse_start();
        for (int i = 0; i < vecs[v].len; i++) begin
            if (gaps) begin
                rx_valid = 1'b0;
                @(posedge clk); #1;
                if (i == 6) start = 1'b1;
            end
            send_byte(frame_byte(v, i));
            start = 1'b0;
        end
        // result must be visible right after the check byte is taken
        check({tag, "_done_now"},  {31'b0, done},  {31'b0, vecs[v].exp_done});
        check({tag, "_error_now"}, {31'b0, error}, {31'b0, vecs[v].exp_error});
        repeat (3) @(posedge clk);
        #1;
        check_result(v, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // CHK = xor of payload: 04^08^0C=00, 00^10^20=30, 9F^9F^9F=9F, E5^E5^E5=E5 -> 4A
        vecs[0] = '{"prog3", 128'h03000400_9FE50810_9FE50C20_9FE54A00, 15, 3,
                    {32'hE59F200C, 32'hE59F1008, 32'hE59F0004}, 1'b1, 1'b0};
        vecs[1] = '{"badchk", 128'h03000400_9FE50810_9FE50C20_9FE5FF00, 15, 3,
                    {32'hE59F200C, 32'hE59F1008, 32'hE59F0004}, 1'b0, 1'b1};
        vecs[2] = '{"empty_ok", 128'h0, 3, 0, 96'h0, 1'b1, 1'b0};
        vecs[3] = '{"empty_bad", 128'h00000100_00000000_00000000_00000000, 3, 0, 96'h0, 1'b0, 1'b1};
        // 78^56^34^12 = 08
        vecs[4] = '{"one_word", 128'h01007856_34120800_00000000_00000000, 7, 1,
                    {64'h0, 32'h12345678}, 1'b1, 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        overlap  = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rx_ready", {31'b0, rx_ready}, 32'h0);
        check("rst_imem_we",  {31'b0, imem_we},  32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_imem_wd",   imem_wd,   32'h0);
        check("rst_cpu_hold", {31'b0, cpu_hold}, 32'h1);
        check("rst_busy",     {31'b0, busy},     32'h0);
        check("rst_done",     {31'b0, done},     32'h0);
        check("rst_error",    {31'b0, error},    32'h0);
        check("rst_words",    {21'b0, words_loaded}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_no_ready", {31'b0, rx_ready}, 32'h0);

        for (int v = 0; v < 5; v++) begin
            run_frame(v, 1'b0, vecs[v].name);
            $display("frame %s: done=%0b error=%0b words=%0d writes=%0d",
                     vecs[v].name, done, error, words_loaded, wr_addr_q.size());
        end

        // N = 1025 exceeds DEPTH: reject one cycle after the second header byte
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h01);
        check("big_hdr1_busy",  {31'b0, busy},  32'h1);
        check("big_hdr1_error", {31'b0, error}, 32'h0);
        send_byte(8'h04);
        check("big_error",    {31'b0, error},    32'h1);
        check("big_rx_ready", {31'b0, rx_ready}, 32'h0);
        check("big_cpu_hold", {31'b0, cpu_hold}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("big_nwrites", wr_addr_q.size(), 32'h0);
        check("big_words",   {21'b0, words_loaded}, 32'h0);
        $display("frame oversize: error=%0b writes=%0d", error, wr_addr_q.size());

        run_frame(0, 1'b1, "gaps");
        $display("frame gaps: done=%0b words=%0d writes=%0d", done, words_loaded, wr_addr_q.size());

        // reset after six payload bytes, leaving a half-assembled second word
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(frame_byte(0, i));
        @(posedge clk); #1;
        check("mid_words_pre", {21'b0, words_loaded}, 32'h1);
        rst_n = 1'b0;
        #2;
        check("mid_rx_ready", {31'b0, rx_ready}, 32'h0);
        check("mid_imem_we",  {31'b0, imem_we},  32'h0);
        check("mid_imem_addr", imem_addr, 32'h0);
        check("mid_imem_wd",   imem_wd,   32'h0);
        check("mid_cpu_hold", {31'b0, cpu_hold}, 32'h1);
        check("mid_busy",     {31'b0, busy},     32'h0);
        check("mid_done",     {31'b0, done},     32'h0);
        check("mid_error",    {31'b0, error},    32'h0);
        check("mid_words",    {21'b0, words_loaded}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_frame(0, 1'b0, "after_rst");
        $display("frame after_rst: done=%0b words=%0d writes=%0d", done, words_loaded, wr_addr_q.size());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
